// File: rtl/adc_align_sequencer.sv
// Sequences the ADC data-alignment channels one at a time, with settle, timeout and retry per channel.
// Optional build macro ALIGN_STABLE_CHECK_EN: a pass needs 4 consecutive high completion samples.
module adc_align_sequencer #(
  parameter int CHANNELS    = 8,
  parameter int SETTLE_CYC  = 16,
  parameter int TIMEOUT_CYC = 4096,
  parameter int MAX_RETRY   = 3
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      start,
  input  logic                                      abort,
  input  logic [CHANNELS-1:0]                       ch_mask,
  input  logic [CHANNELS-1:0]                       align_cmpl_i,
  output logic [CHANNELS-1:0]                       en_align_o,
  output logic                                      busy,
  output logic                                      done,
  output logic [CHANNELS-1:0]                       pass_mask,
  output logic [CHANNELS-1:0]                       fail_mask,
  output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] cur_ch,
  output logic [3:0]                                attempt
);

  localparam int CHW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int IDXW = $clog2(CHANNELS + 1);
  localparam int CNTW = 21;

  typedef enum logic [2:0] {IDLE, SELECT, SETTLE, WAIT, DONE} state_t;

  state_t               state_q, state_d;
  logic [CNTW-1:0]      cnt_q, cnt_d;
  logic [CHANNELS-1:0]  mask_q, mask_d;
  logic [IDXW-1:0]      idx_q, idx_d;
  logic [CHW-1:0]       cur_ch_q, cur_ch_d;
  logic [3:0]           attempt_q, attempt_d;
  logic [CHANNELS-1:0]  pass_q, pass_d;
  logic [CHANNELS-1:0]  fail_q, fail_d;
  logic [CHANNELS-1:0]  en_q, en_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 sel_found;
  logic [CHW-1:0]       sel_idx;
  logic                 eligible;
  logic                 accept;
  logic                 timeout;
`ifdef ALIGN_STABLE_CHECK_EN
  logic [2:0]           run_q, run_d;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mask_q    <= '0;
      idx_q     <= '0;
      cur_ch_q  <= '0;
      attempt_q <= '0;
      pass_q    <= '0;
      fail_q    <= '0;
      en_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef ALIGN_STABLE_CHECK_EN
      run_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mask_q    <= mask_d;
      idx_q     <= idx_d;
      cur_ch_q  <= cur_ch_d;
      attempt_q <= attempt_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      en_q      <= en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef ALIGN_STABLE_CHECK_EN
      run_q     <= run_d;
`endif
    end
  end

  // Lowest latched channel at or above the scan index.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (mask_q[i] && (i >= int'(idx_q))) begin
        sel_found = 1'b1;
        sel_idx   = CHW'(i);
      end
    end
  end

  // The first two WAIT cycles ignore the flag so a stale completion is never taken.
  assign eligible = (cnt_q >= CNTW'(2));
  assign timeout  = (cnt_q == CNTW'(TIMEOUT_CYC - 1));

`ifdef ALIGN_STABLE_CHECK_EN
  always_comb begin
    run_d  = '0;
    accept = 1'b0;
    if (state_q == WAIT && eligible && align_cmpl_i[cur_ch_q]) begin
      accept = (run_q == 3'd3);
      run_d  = run_q + 3'd1;
    end
    if (state_d != state_q) begin
      run_d = '0;
    end
  end
`else
  assign accept = eligible && align_cmpl_i[cur_ch_q];
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mask_d    = mask_q;
    idx_d     = idx_q;
    cur_ch_d  = cur_ch_q;
    attempt_d = attempt_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    en_d      = '0;

    if (abort && (state_q == SELECT || state_q == SETTLE || state_q == WAIT)) begin
      state_d = IDLE;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            mask_d  = ch_mask;
            pass_d  = '0;
            fail_d  = '0;
            idx_d   = '0;
            busy_d  = 1'b1;
            state_d = SELECT;
          end
        end
        SELECT: begin
          if (sel_found) begin
            cur_ch_d  = sel_idx;
            attempt_d = 4'd1;
            state_d   = SETTLE;
          end else begin
            state_d = DONE;
          end
        end
        SETTLE: begin
          cnt_d = cnt_q + CNTW'(1);
          if (cnt_q == CNTW'(SETTLE_CYC - 1)) begin
            state_d = WAIT;
          end
        end
        WAIT: begin
          // Enable trails the state by one edge, so a retry leaves it low for exactly SETTLE_CYC cycles.
          en_d[cur_ch_q] = 1'b1;
          cnt_d          = cnt_q + CNTW'(1);
          if (accept) begin
            pass_d[cur_ch_q] = 1'b1;
            idx_d            = IDXW'(cur_ch_q) + IDXW'(1);
            state_d          = SELECT;
          end else if (timeout) begin
            if (attempt_q < 4'(MAX_RETRY)) begin
              attempt_d = attempt_q + 4'd1;
              state_d   = SETTLE;
            end else begin
              fail_d[cur_ch_q] = 1'b1;
              idx_d            = IDXW'(cur_ch_q) + IDXW'(1);
              state_d          = SELECT;
            end
          end
        end
        DONE: begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    if (state_d != state_q) begin
      cnt_d = '0;
    end
  end

  assign en_align_o = en_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass_mask  = pass_q;
  assign fail_mask  = fail_q;
  assign cur_ch     = cur_ch_q;
  assign attempt    = attempt_q;

endmodule

// File: tb/tb_adc_align_sequencer.sv
// Directed bench for adc_align_sequencer with a small datapath responder; expectations are hand-derived.
module tb_adc_align_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] ch_mask = '0;
  logic [7:0] align_cmpl_i = '0;
  logic [7:0] en_align_o;
  logic       busy;
  logic       done;
  logic [7:0] pass_mask;
  logic [7:0] fail_mask;
  logic [2:0] cur_ch;
  logic [3:0] attempt;

  adc_align_sequencer #(
    .CHANNELS(8), .SETTLE_CYC(4), .TIMEOUT_CYC(16), .MAX_RETRY(2)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .ch_mask(ch_mask),
    .align_cmpl_i(align_cmpl_i), .en_align_o(en_align_o), .busy(busy), .done(done),
    .pass_mask(pass_mask), .fail_mask(fail_mask), .cur_ch(cur_ch), .attempt(attempt)
  );

  always #5 clk = ~clk;

  int vecCount = 0;
  int errCount = 0;

  int kNow;
  int doneCount;
  int doneK;
  int oneHotErr;
  int enHighTotal;
  logic [7:0] prevEn;
  logic [7:0] everEn;
  int enRun[8];
  int enRises[8];
  int firstRise[8];
  int lastFall[8];
  int gapK[8];
  int riseAttempt[8];
  bit respOn;
  int respDelay;
  int respAttempt;

`ifdef ALIGN_STABLE_CHECK_EN
  localparam int STALE_PASS_K = 11;
  localparam int PATTERN_PASS_K = 13;
`else
  localparam int STALE_PASS_K = 8;
  localparam int PATTERN_PASS_K = 8;
`endif

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vecCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic clearMonitors();
    kNow = 0; doneCount = 0; doneK = -1; oneHotErr = 0; enHighTotal = 0;
    prevEn = '0; everEn = '0;
    for (int i = 0; i < 8; i++) begin
      enRun[i] = 0; enRises[i] = 0; firstRise[i] = -1;
      lastFall[i] = -1; gapK[i] = -1; riseAttempt[i] = 0;
    end
  endtask

  // Samples the DUT at the current falling edge, plays the datapath, then moves to the next falling edge.
  task automatic stepCycle();
    if ((en_align_o & (en_align_o - 8'd1)) != 8'd0) oneHotErr++;
    if (done) begin
      doneCount++;
      if (doneK < 0) doneK = kNow;
    end
    everEn = everEn | en_align_o;
    for (int i = 0; i < 8; i++) begin
      if (en_align_o[i]) begin
        enHighTotal++;
        enRun[i]++;
        if (!prevEn[i]) begin
          enRises[i]++;
          riseAttempt[i] = int'(attempt);
          if (firstRise[i] < 0) firstRise[i] = kNow;
          if (lastFall[i] >= 0) gapK[i] = kNow - lastFall[i];
        end
      end else begin
        enRun[i] = 0;
        if (prevEn[i]) lastFall[i] = kNow;
      end
      if (respOn) begin
        align_cmpl_i[i] = en_align_o[i] && (enRun[i] > respDelay) && (enRises[i] >= respAttempt);
      end
    end
    prevEn = en_align_o;
    @(negedge clk);
    kNow++;
  endtask

  task automatic applyStimulus(input logic [7:0] mask, input logic [7:0] preCmpl);
    clearMonitors();
    @(negedge clk);
    align_cmpl_i = preCmpl;
    ch_mask = mask;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ch_mask = 8'h00;
    kNow = 0;
  endtask

  task automatic waitDone(input string tag, input int budget);
    int n;
    n = 0;
    while (doneCount == 0 && n < budget) begin
      stepCycle();
      n++;
    end
    checkOutput({tag, "_doneSeen"}, (doneCount != 0), 1'b1);
    repeat (3) stepCycle();
  endtask

  initial begin
    int n;
    respOn = 1'b0; respDelay = 5; respAttempt = 1;
    clearMonitors();
    #12;
    checkOutput("rst_en", en_align_o, 8'h00);
    checkOutput("rst_busyDone", {busy, done}, 2'b00);
    checkOutput("rst_masks", {pass_mask, fail_mask}, 16'h0000);
    checkOutput("rst_chAtt", {cur_ch, attempt}, 7'd0);
    @(negedge clk);
    rst = 1'b1;

    // Basic two-channel sweep
    respOn = 1'b1; respDelay = 5; respAttempt = 1;
    applyStimulus(8'h05, 8'h00);
    checkOutput("basic_busy", busy, 1'b1);
    waitDone("basic", 200);
    checkOutput("basic_firstRise0", firstRise[0], 6);
    checkOutput("basic_pass", pass_mask, 8'h05);
    checkOutput("basic_fail", fail_mask, 8'h00);
    checkOutput("basic_doneCount", doneCount, 1);
    checkOutput("basic_oneHot", oneHotErr, 0);
    checkOutput("basic_everEn", everEn, 8'h05);
    checkOutput("basic_busyEnd", busy, 1'b0);

    // Retry then pass on the second attempt
    respOn = 1'b1; respDelay = 5; respAttempt = 2;
    applyStimulus(8'h02, 8'h00);
    waitDone("retry", 200);
    checkOutput("retry_rises", enRises[1], 2);
    checkOutput("retry_attempt2", riseAttempt[1], 2);
    checkOutput("retry_gap", gapK[1], 4);
    checkOutput("retry_pass", pass_mask, 8'h02);
    checkOutput("retry_fail", fail_mask, 8'h00);

    // Retries exhausted
    respOn = 1'b0;
    applyStimulus(8'h80, 8'h00);
    waitDone("exhaust", 200);
    checkOutput("exhaust_rises", enRises[7], 2);
    checkOutput("exhaust_enHigh", enHighTotal, 32);
    checkOutput("exhaust_fail", fail_mask, 8'h80);
    checkOutput("exhaust_pass", pass_mask, 8'h00);
    checkOutput("exhaust_doneCount", doneCount, 1);

    // Empty mask
    applyStimulus(8'h00, 8'h00);
    waitDone("empty", 20);
    checkOutput("empty_doneK", doneK, 2);
    checkOutput("empty_enHigh", enHighTotal, 0);
    checkOutput("empty_masks", {pass_mask, fail_mask}, 16'h0000);

    // Start while busy is ignored
    respOn = 1'b1; respDelay = 5; respAttempt = 1;
    applyStimulus(8'h0F, 8'h00);
    repeat (20) stepCycle();
    start = 1'b1; ch_mask = 8'hFF;
    stepCycle();
    start = 1'b0; ch_mask = 8'h00;
    waitDone("busyStart", 300);
    checkOutput("busyStart_pass", pass_mask, 8'h0F);
    checkOutput("busyStart_everEn", everEn, 8'h0F);
    checkOutput("busyStart_doneCount", doneCount, 1);

    // Abort during channel 2 WAIT
    applyStimulus(8'hFF, 8'h00);
    n = 0;
    while (!(en_align_o == 8'h04 && enRun[2] == 2) && n < 300) begin
      stepCycle();
      n++;
    end
    checkOutput("abort_reached", (n < 300), 1'b1);
    abort = 1'b1;
    stepCycle();
    abort = 1'b0;
    checkOutput("abort_en", en_align_o, 8'h00);
    checkOutput("abort_busy", busy, 1'b0);
    checkOutput("abort_pass", pass_mask, 8'h03);
    checkOutput("abort_chAtt", {cur_ch, attempt}, {3'd2, 4'd1});
    repeat (10) stepCycle();
    checkOutput("abort_noDone", doneCount, 0);

    // Asynchronous reset mid-WAIT
    applyStimulus(8'hFF, 8'h00);
    n = 0;
    while (en_align_o != 8'h02 && n < 300) begin
      stepCycle();
      n++;
    end
    checkOutput("rstMid_reached", (n < 300), 1'b1);
    respOn = 1'b0;
    align_cmpl_i = 8'h00;
    #2 rst = 1'b0;
    #1;
    checkOutput("rstMid_en", en_align_o, 8'h00);
    checkOutput("rstMid_busy", busy, 1'b0);
    checkOutput("rstMid_pass", pass_mask, 8'h00);
    checkOutput("rstMid_chAtt", {cur_ch, attempt}, 7'd0);
    @(negedge clk);
    rst = 1'b1;

    // Stale flag held high before the sweep
    respOn = 1'b0;
    applyStimulus(8'h08, 8'h08);
    repeat (STALE_PASS_K - 1) stepCycle();
    checkOutput("stale_early", pass_mask, 8'h00);
    stepCycle();
    checkOutput("stale_pass", pass_mask, 8'h08);
    align_cmpl_i = 8'h00;
    waitDone("stale", 100);

    // 1-0-1-1-1-1 pattern on the eligible WAIT cycles
    applyStimulus(8'h08, 8'h00);
    for (int k = 0; k <= PATTERN_PASS_K; k++) begin
      logic [5:0] pat;
      pat = 6'b111101;
      align_cmpl_i[3] = (k >= 7 && k <= 12) ? pat[k - 7] : 1'b0;
      if (k == PATTERN_PASS_K - 1) checkOutput("pattern_early", pass_mask, 8'h00);
      if (k == PATTERN_PASS_K) checkOutput("pattern_pass", pass_mask, 8'h08);
      if (k < PATTERN_PASS_K) stepCycle();
    end
    align_cmpl_i = 8'h00;
    waitDone("pattern", 100);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
